// File: rtl/bitstream_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// bitstream_unpacker_pkg : shared width defaults, buffer states, field extender
// Revision: 1.0
// ============================================================================
package bitstream_unpacker_pkg;

  localparam int DEFAULT_N = 16;

  // Field extension is evaluated at a fixed wide width so any N <= EXT_W
  // can reuse it; callers truncate the result to their own N.
  localparam int EXT_W  = 64;
  localparam int EXT_LW = 7;

  localparam logic [1:0] BUF_EMPTY   = 2'd0;
  localparam logic [1:0] BUF_PARTIAL = 2'd1;
  localparam logic [1:0] BUF_FULL    = 2'd2;

  function automatic int level_w(input int m);
    return m + 2;
  endfunction

  // Keep the low len bits of field; fill the rest with copies of bit len-1
  // when sgn is set, zeros otherwise. len is 1..EXT_W.
  function automatic logic [EXT_W-1:0] ext(input logic [EXT_W-1:0] field,
                                           input logic [EXT_LW-1:0] len,
                                           input logic sgn);
    logic [EXT_W-1:0] mask;
    logic [EXT_W-1:0] top;
    if (len >= EXT_LW'(EXT_W)) begin
      mask = '1;
    end else begin
      mask = (EXT_W'(1) << len) - EXT_W'(1);
    end
    top = field >> (len - EXT_LW'(1));
    if (sgn && top[0]) begin
      return field | ~mask;
    end
    return field & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bitstream_unpacker_extract.sv
`default_nettype none
// ============================================================================
// bitstream_extract : combinational field shifter and buffer update
// Revision: 1.0
// ============================================================================
module bitstream_extract
  import bitstream_unpacker_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int M = $clog2(N)
) (
  input  logic [2*N-1:0] bit_buf,
  input  logic [M+1:0]   level,
  input  logic [M:0]     len,
  input  logic [N-1:0]   in_data,
  input  logic           push,
  input  logic           pop,
  output logic [N-1:0]   field,
  output logic [2*N-1:0] next_buf,
  output logic [M+1:0]   next_level
);

  localparam int LW = M + 2;

  logic [LW-1:0]  rsh;
  logic [2*N-1:0] popped_buf;
  logic [LW-1:0]  popped_level;
  logic [2*N-1:0] push_word;

  always_comb begin
    rsh          = LW'(2 * N) - LW'(len);
    field        = N'(bit_buf >> rsh);

    popped_buf   = bit_buf;
    popped_level = level;
    if (pop) begin
      popped_buf   = bit_buf << len;
      popped_level = level - LW'(len);
    end

    // New word lands directly below the bits that survive this cycle's pop.
    push_word  = {in_data, {N{1'b0}}} >> popped_level;
    next_buf   = popped_buf;
    next_level = popped_level;
    if (push) begin
      next_buf   = popped_buf | push_word;
      next_level = popped_level + LW'(N);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bitstream_unpacker.sv
`default_nettype none
// ============================================================================
// bitstream_unpacker : MSB-first variable-length field reader over N-bit words
// Revision: 1.0
// ============================================================================
module bitstream_unpacker
  import bitstream_unpacker_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int M = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_data,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [M-1:0]          req_len,
  input  logic                  req_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N-1:0]          out_data,
  output logic [level_w(M)-1:0] level
);

  localparam int LW = level_w(M);

  logic [2*N-1:0] buf_q, buf_d;
  logic [LW-1:0]  level_q, level_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_data_q, out_data_d;

  logic [M:0]     len;
  logic [1:0]     buf_state;
  logic           push;
  logic           pop;
  logic [N-1:0]   field;
  logic [2*N-1:0] next_buf;
  logic [LW-1:0]  next_level;

  always_comb begin
    len = (M+1)'(req_len) + (M+1)'(1);

    if (level_q == '0) begin
      buf_state = BUF_EMPTY;
    end else if (level_q <= LW'(N)) begin
      buf_state = BUF_PARTIAL;
    end else begin
      buf_state = BUF_FULL;
    end

    // Both qualifiers look only at the registered level, so a word arriving
    // this cycle never satisfies this cycle's request.
    in_ready  = !flush && (buf_state != BUF_FULL);
    req_ready = !flush && (level_q >= LW'(len)) && (!out_valid_q || out_ready);
    push      = in_valid && in_ready;
    pop       = req_valid && req_ready;
  end

  bitstream_extract #(
    .N (N),
    .M (M)
  ) u_extract (
    .bit_buf    (buf_q),
    .level      (level_q),
    .len        (len),
    .in_data    (in_data),
    .push       (push),
    .pop        (pop),
    .field      (field),
    .next_buf   (next_buf),
    .next_level (next_level)
  );

  always_comb begin
    buf_d       = buf_q;
    level_d     = level_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (flush) begin
      buf_d       = '0;
      level_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      buf_d   = next_buf;
      level_d = next_level;
      if (pop) begin
        out_valid_d = 1'b1;
        out_data_d  = N'(ext(EXT_W'(field), EXT_LW'(len), req_signed));
      end else if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q       <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      buf_q       <= buf_d;
      level_q     <= level_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign level     = level_q;

endmodule
`default_nettype wire
